// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA shifter. Each clock shifts by up to STEP bit positions.
// Define ITER_SHIFTER_ROTATE_EN to make op=11 a rotate right; otherwise op=11 acts as SRL.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

  // Handshake: start is sampled only in IDLE; busy is high for every SHIFT
  // cycle; done pulses for one cycle once result holds the new value.
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_shifted;
  logic [AW-1:0]    rem, n;
  logic [1:0]       op_q;
  logic             sign_q;
  logic             unused_b;

  // Only the low AW bits of b form the amount, so b = WIDTH wraps to 0.
  assign unused_b = ^b[WIDTH-1:AW];

  // n = min(rem, STEP); the STEP branch only fires when STEP < WIDTH, so it fits AW bits.
  always_comb begin
    n = rem;
    if ({1'b0, rem} > STEP_W) n = STEP_W[AW-1:0];
  end

  always_comb begin
    work_shifted = work >> n;
    case (op_q)
      2'b00: work_shifted = work << n;
      2'b10: work_shifted = (work >> n) | ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> n));
`ifdef ITER_SHIFTER_ROTATE_EN
      2'b11: work_shifted = (work >> n) | (work << (WIDTH - int'(n)));
`endif
      default: work_shifted = work >> n;
    endcase
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (rem == n) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      rem    <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          work   <= a;
          op_q   <= op;
          rem    <= b[AW-1:0];
          sign_q <= a[WIDTH-1];
        end
        SHIFT: begin
          work <= work_shifted;
          rem  <= rem - n;
          // result only moves on the final step so it stays stable while busy.
          if (rem == n) result <= work_shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (WIDTH=32, STEP=4): vector table,
// handshake/reset sequences and randomized operations against a whole-shift model.
module tb_iter_shifter;
  localparam int W    = 32;
  localparam int STEP = 4;

  logic         clk, rst_n, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  iter_shifter #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           cyc;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: one whole shift by the wrapped amount.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int amt;
    amt = int'(bv % W);
    case (o)
      2'b00: return av << amt;
      2'b10: return W'($signed(av) >>> amt);
`ifdef ITER_SHIFTER_ROTATE_EN
      2'b11: return (amt == 0) ? av : ((av >> amt) | (av << (W - amt)));
`endif
      default: return av >> amt;
    endcase
  endfunction

  function automatic int model_cycles(input logic [W-1:0] bv);
    int amt;
    amt = int'(bv % W);
    return (amt == 0) ? 1 : (amt + STEP - 1) / STEP;
  endfunction

  // Called just after a negedge. Holds start until busy appears, then counts
  // busy cycles and captures result at the done cycle. hold=1 keeps start
  // high with junk operands for one SHIFT cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold, output logic [W-1:0] res, output int cyc,
                        output bit done_seen, output bit done_once, output bit stable);
    int g;
    logic [W-1:0] prev;
    prev = result;
    op = o; a = av; b = bv; start = 1'b1;
    cyc = 0; g = 0; stable = 1'b1;
    do begin
      @(negedge clk);
      g++;
    end while (!busy && g < 10);
    if (hold) begin
      op = 2'(op + 1); a = $urandom; b = $urandom;
      if (busy) cyc++;
      if (result !== prev) stable = 1'b0;
      @(negedge clk);
    end
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    g = 0;
    while (busy && g < 200) begin
      cyc++;
      if (result !== prev) stable = 1'b0;
      @(negedge clk);
      g++;
    end
    done_seen = done;
    res = result;
    @(negedge clk);
    done_once = !done;
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] res, e;
    int cyc, g;
    bit ds, d1, st;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    bit seen;

    vecs[0] = '{2'b10, 32'h8000_0000, 32'h0000_0001, 32'hC000_0000, 1};
    vecs[1] = '{2'b10, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 8};
    vecs[2] = '{2'b01, 32'h08DF_0000, 32'h0000_0005, 32'h0046_F800, 2};
    vecs[3] = '{2'b00, 32'h4000_0000, 32'h0000_0002, 32'h0000_0000, 1};
    vecs[4] = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};
    vecs[5] = '{2'b00, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1};
    vecs[6] = '{2'b01, 32'h8000_0000, 32'hFFFF_FF01, 32'h4000_0000, 1};
`ifdef ITER_SHIFTER_ROTATE_EN
    vecs[7] = '{2'b11, 32'h0000_0001, 32'h0000_0004, 32'h1000_0000, 1};
`else
    vecs[7] = '{2'b11, 32'h0000_0001, 32'h0000_0004, 32'h0000_0000, 1};
`endif
    vecs[8] = '{2'b10, 32'h7FFF_FFFF, 32'h0000_0004, 32'h07FF_FFFF, 1};
    vecs[9] = '{2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 8};

    // Clock/reset
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, cyc, ds, d1, st);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_cycles", i), W'(cyc), W'(vecs[i].cyc));
      check($sformatf("vec%0d_done", i), W'(ds), W'(1));
      check($sformatf("vec%0d_done_once", i), W'(d1), W'(1));
      check($sformatf("vec%0d_stable", i), W'(st), W'(1));
    end

    // start during SHIFT is ignored; the following IDLE start is accepted
    run_op(2'b01, 32'hF000_0000, 32'h0000_0008, 1'b1, res, cyc, ds, d1, st);
    check("ignore_result", res, 32'h00F0_0000);
    check("ignore_cycles", W'(cyc), W'(2));
    check("ignore_done_once", W'(d1), W'(1));
    run_op(2'b00, 32'h0000_00FF, 32'h0000_0004, 1'b0, res, cyc, ds, d1, st);
    check("b2b_result", res, 32'h0000_0FF0);
    check("b2b_done", W'(ds), W'(1));

    // Reset in the 3rd SHIFT cycle of SRA by 20
    op = 2'b10; a = 32'h8000_0000; b = 32'd20; start = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!busy && g < 10);
    start = 1'b0;
    check("rst_seq_busy_before", W'(busy), W'(1));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_done", W'(done), '0);
    check("rst_mid_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst_no_done", W'(seen), '0);

    // Randomized operations through the scoreboard
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 0) ? $urandom : W'($urandom_range(0, W));
      exp_q.push_back(model(ro, ra, rb));
      run_op(ro, ra, rb, 1'b0, res, cyc, ds, d1, st);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, ro, ra, rb), res, e);
      check($sformatf("rand%0d_cycles", i), W'(cyc), W'(model_cycles(rb)));
      check($sformatf("rand%0d_done_once", i), W'(ds & d1 & st), W'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
- Parametrised, multi-cycle successor to the combinational arithmetic right shifter in the ALU.
- Performs SLL, SRL and SRA on a WIDTH-bit operand, applying up to STEP bit positions per clock.
- Uses a start/busy/done handshake, so the ALU controller can trade latency for area.
- Result is held stable until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, at least 8.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 to WIDTH.
- AW, $clog2(WIDTH), derived local parameter: number of shift-amount bits used from b.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature).
- a  input  WIDTH  operand to shift.
- b  input  WIDTH  shift amount; only b[AW-1:0] used, upper bits ignored.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse when result is valid.
- result  output  WIDTH  shifted value; registered.

Behaviour:
- Reset: asserting rst_n low takes effect immediately, without waiting for clk.
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - Internal working register and remaining count are cleared.
  - A reset mid-operation aborts it; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at a clk edge: capture a into the working register, capture op, capture rem=b[AW-1:0], go to SHIFT.
  - a, b and op are not sampled again after capture.
- SHIFT, per cycle:
  - n = min(rem, STEP); shift the working register by n; rem -= n.
  - busy=1.
  - When rem reaches 0 at this edge: result <= working value, go to DONE.
  - rem=0 at capture still spends exactly one SHIFT cycle with n=0.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Handshake:
  - start is ignored while in SHIFT or DONE.
  - Back-to-back operation: start may be asserted in the cycle after DONE (IDLE).
- Latency:
  - SHIFT cycles = max(1, ceil(amt/STEP)).
  - done is asserted in the cycle after the last SHIFT cycle.
  - Example: WIDTH=32, STEP=4, amt=31 gives 8 SHIFT cycles, with done 9 cycles after the start edge.
- Arithmetic:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the captured a[WIDTH-1] on every step (sign preserved across steps).
- Width rules:
  - Amounts are 0 to WIDTH-1 only.
  - b = WIDTH (e.g. 0x20 for WIDTH=32) wraps to amount 0, so result = a.
- result holds its value in IDLE, SHIFT and DONE until the next completion; it does not change during SHIFT.

Optional Feature:
- Macro: ITER_SHIFTER_ROTATE_EN.
- Defined: op=11 performs rotate right; bits leaving bit 0 re-enter at bit WIDTH-1 each step. Latency is the same as the other operations.
- Undefined: op=11 behaves exactly as SRL (01), and no rotate logic is synthesised.

Test Plan:
- SRA, a=0x80000000, b=1 -> done after 1 SHIFT cycle, result=0xC0000000; with a=0x80000000, b=0x1F -> result=0xFFFFFFFF, busy high for 8 cycles (STEP=4).
- SRL, a=0x08DF0000, b=5 -> result=0x0046F800 after 2 SHIFT cycles; SLL, a=0x40000000, b=2 -> result=0x00000000.
- Boundary amounts:
  - b=0 -> 1 SHIFT cycle, result=a.
  - b=0x20 -> treated as 0, result=a.
  - b=0xFFFFFF01 -> amount 1.
- Handshake:
  - pulse start with SRL a=0xF0000000, b=8; re-assert start with different a/b during SHIFT -> ignored, result=0x00F00000.
  - done high exactly one cycle.
  - a new start in the next IDLE cycle is accepted.
- Reset mid-operation: start SRA, b=20; drop rst_n during the 3rd SHIFT cycle -> busy, done and result go to 0 immediately; after release, no done pulse until a new start.
- ITER_SHIFTER_ROTATE_EN:
  - defined: op=11, a=0x00000001, b=4 -> 0x10000000.
  - undefined: same stimulus -> 0x00000000.
